// File: rtl/vga_pkg.sv
// Shared definitions for the VGA mode / pattern generator.
//   mode_e      : output source selection (bars, checkerboard, gradient, stream)
//   *_DEF       : power-on 640x480@60 timing (active, sync start, sync end, total)
//   geom_ok()   : one-axis geometry sanity test used before a new set is accepted
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_STREAM = 2'd3
  } mode_e;

  localparam int unsigned H_WIDTH_DEF  = 640;
  localparam int unsigned H_PORCH_DEF  = 656;
  localparam int unsigned H_SYNCH_DEF  = 752;
  localparam int unsigned H_RAW_DEF    = 800;
  localparam int unsigned V_HEIGHT_DEF = 480;
  localparam int unsigned V_PORCH_DEF  = 490;
  localparam int unsigned V_SYNCH_DEF  = 492;
  localparam int unsigned V_RAW_DEF    = 525;

  localparam int unsigned H_WIDTH_MIN  = 8;
  localparam int unsigned V_HEIGHT_MIN = 1;

  // len <= porch < synch <= raw-1, written as synch < raw so raw=0 cannot underflow.
  function automatic logic geom_ok(input int unsigned len, input int unsigned min_len,
                                   input int unsigned porch, input int unsigned synch,
                                   input int unsigned raw);
    return (len >= min_len) && (len <= porch) && (porch < synch) && (synch < raw);
  endfunction

endpackage

// File: rtl/vga_mode_pattern_gen_if.sv
// Pixel stream input and video output bundle of the pattern generator.
//   i_pixel / i_pix_valid / o_pix_ready : stream source handshake (mode 3)
//   o_hsync / o_vsync                   : active-low syncs
//   o_de / o_pixel                      : data enable and pixel, channel 0 in LSBs
//   o_frame_start / o_underflow         : frame marker and starved-pixel pulse
// Modports: master = stream source / video sink, slave = generator.
interface vga_mode_pattern_gen_if #(
  parameter int PW = 24
);
  logic [PW-1:0] i_pixel;
  logic          i_pix_valid;
  logic          o_pix_ready;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic [PW-1:0] o_pixel;
  logic          o_frame_start;
  logic          o_underflow;

  modport master (
    output i_pixel, i_pix_valid,
    input  o_pix_ready, o_hsync, o_vsync, o_de, o_pixel, o_frame_start, o_underflow
  );

  modport slave (
    input  i_pixel, i_pix_valid,
    output o_pix_ready, o_hsync, o_vsync, o_de, o_pixel, o_frame_start, o_underflow
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical) of the generator.
//   clk, rst : clock, asynchronous active-high reset
//   run      : 0 holds the position at 0 (generator disabled)
//   step     : advance by one this cycle
//   len/porch/synch/raw : active length, sync start, sync end, total count
//   pos      : current position 0..raw-1
//   wrap     : position returns to 0 on this clock edge
//   active   : pos < len
//   in_sync  : porch <= pos < synch
module vga_axis_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         step,
  input  logic [W-1:0] len,
  input  logic [W-1:0] porch,
  input  logic [W-1:0] synch,
  input  logic [W-1:0] raw,
  output logic [W-1:0] pos,
  output logic         wrap,
  output logic         active,
  output logic         in_sync
);
  logic [W-1:0] pos_reg;
  logic [W-1:0] pos_next;
  logic         last;

  assign last = (pos_reg == raw - W'(1));
  assign wrap = run && step && last;

  always_comb begin
    pos_next = pos_reg;
    if (!run)
      pos_next = '0;
    else if (step)
      pos_next = last ? '0 : pos_reg + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_reg <= '0;
    else     pos_reg <= pos_next;
  end

  assign pos     = pos_reg;
  assign active  = (pos_reg < len);
  assign in_sync = (pos_reg >= porch) && (pos_reg < synch);
endmodule

// File: rtl/vga_mode_pattern_gen.sv
// VGA timing generator with built-in test patterns and a stream passthrough.
//   i_clk, i_reset      : pixel clock, asynchronous active-high reset
//   i_en                : enable; low holds counters at (0,0) with idle outputs
//   i_mode              : 0 bars, 1 checkerboard, 2 gradient, 3 stream
//   i_hm_* / i_vm_*     : active, sync start, sync end, total per axis
//   bus (slave)         : stream handshake and registered video outputs
// Build option: VGA_PATTERN_BORDER_EN forces a full-scale one-pixel frame
// around the active area in the pattern modes (not in stream mode).
// Mode and geometry are sampled only at the frame origin so a frame is
// never torn; an inconsistent geometry set is dropped and the old one kept.
module vga_mode_pattern_gen
  import vga_pkg::*;
#(
  parameter int FW  = 13,
  parameter int LW  = 11,
  parameter int BPC = 8,
  parameter int NCH = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [1:0]    i_mode,
  input  logic [FW-1:0] i_hm_width,
  input  logic [FW-1:0] i_hm_porch,
  input  logic [FW-1:0] i_hm_synch,
  input  logic [FW-1:0] i_hm_raw,
  input  logic [LW-1:0] i_vm_height,
  input  logic [LW-1:0] i_vm_porch,
  input  logic [LW-1:0] i_vm_synch,
  input  logic [LW-1:0] i_vm_raw,
  vga_mode_pattern_gen_if.slave bus
);
  localparam int PW = NCH * BPC;

  // shadow registers
  mode_e         mode_reg;
  logic [FW-1:0] hw_reg, hp_reg, hs_reg, hr_reg;
  logic [LW-1:0] vh_reg, vp_reg, vs_reg, vr_reg;

  // values in effect this cycle: at the origin the incoming set is used
  // directly so pixel (0,0) already belongs to the new frame's settings
  mode_e         cur_mode;
  logic [FW-1:0] cur_hw, cur_hp, cur_hs, cur_hr;
  logic [LW-1:0] cur_vh, cur_vp, cur_vs, cur_vr;
  logic          origin_reg, load_geom;

  logic [FW-1:0] hpos;
  logic [LW-1:0] vpos;
  logic          h_wrap, v_wrap, h_active, v_active, h_in_sync, v_in_sync, active;

  assign load_geom = origin_reg
      && geom_ok(32'(i_hm_width), H_WIDTH_MIN, 32'(i_hm_porch), 32'(i_hm_synch), 32'(i_hm_raw))
      && geom_ok(32'(i_vm_height), V_HEIGHT_MIN, 32'(i_vm_porch), 32'(i_vm_synch), 32'(i_vm_raw));

  assign cur_mode = origin_reg ? mode_e'(i_mode) : mode_reg;
  assign cur_hw   = load_geom ? i_hm_width  : hw_reg;
  assign cur_hp   = load_geom ? i_hm_porch  : hp_reg;
  assign cur_hs   = load_geom ? i_hm_synch  : hs_reg;
  assign cur_hr   = load_geom ? i_hm_raw    : hr_reg;
  assign cur_vh   = load_geom ? i_vm_height : vh_reg;
  assign cur_vp   = load_geom ? i_vm_porch  : vp_reg;
  assign cur_vs   = load_geom ? i_vm_synch  : vs_reg;
  assign cur_vr   = load_geom ? i_vm_raw    : vr_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_reg <= MODE_BARS;
      hw_reg   <= FW'(H_WIDTH_DEF);
      hp_reg   <= FW'(H_PORCH_DEF);
      hs_reg   <= FW'(H_SYNCH_DEF);
      hr_reg   <= FW'(H_RAW_DEF);
      vh_reg   <= LW'(V_HEIGHT_DEF);
      vp_reg   <= LW'(V_PORCH_DEF);
      vs_reg   <= LW'(V_SYNCH_DEF);
      vr_reg   <= LW'(V_RAW_DEF);
    end else begin
      mode_reg <= cur_mode;
      hw_reg   <= cur_hw;
      hp_reg   <= cur_hp;
      hs_reg   <= cur_hs;
      hr_reg   <= cur_hr;
      vh_reg   <= cur_vh;
      vp_reg   <= cur_vp;
      vs_reg   <= cur_vs;
      vr_reg   <= cur_vr;
    end
  end

  vga_axis_counter #(.W(FW)) u_h_axis (
    .clk(i_clk), .rst(i_reset), .run(i_en), .step(1'b1),
    .len(cur_hw), .porch(cur_hp), .synch(cur_hs), .raw(cur_hr),
    .pos(hpos), .wrap(h_wrap), .active(h_active), .in_sync(h_in_sync)
  );

  vga_axis_counter #(.W(LW)) u_v_axis (
    .clk(i_clk), .rst(i_reset), .run(i_en), .step(h_wrap),
    .len(cur_vh), .porch(cur_vp), .synch(cur_vs), .raw(cur_vr),
    .pos(vpos), .wrap(v_wrap), .active(v_active), .in_sync(v_in_sync)
  );

  assign active = h_active && v_active;

  // Tracks (hpos,vpos)==(0,0) without two wide compares: the counters only
  // return to the origin when disabled or when both axes wrap together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) origin_reg <= 1'b1;
    else         origin_reg <= !i_en || (h_wrap && v_wrap);
  end

  // Bar index = floor(hpos*8/width) kept incrementally: acc holds the
  // remainder of hpos*8 modulo width. acc < width and width >= 8, so one
  // subtraction per step is always enough.
  logic [FW-1:0] acc_reg, acc_next;
  logic [FW:0]   acc_sum, acc_diff;
  logic [2:0]    bar_reg, bar_next;

  assign acc_sum  = {1'b0, acc_reg} + (FW+1)'(8);
  assign acc_diff = acc_sum - {1'b0, cur_hw};

  always_comb begin
    acc_next = acc_sum[FW-1:0];
    bar_next = bar_reg;
    if (!i_en || h_wrap) begin
      acc_next = '0;
      bar_next = '0;
    end else if (acc_sum >= {1'b0, cur_hw}) begin
      acc_next = acc_diff[FW-1:0];
      bar_next = bar_reg + 3'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_reg <= '0;
      bar_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      bar_reg <= bar_next;
    end
  end

  // per-channel pattern sources
  logic [PW-1:0] bars_pix, check_pix, grad_pix, pattern;
  logic          check_on;

  assign check_on = hpos[3] ^ vpos[3];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic bar_on;
      always_comb begin
        bar_on = 1'b0;
        for (int k = 0; k < 3; k++)
          if ((k % NCH) == gi) bar_on = bar_on | bar_reg[k];
      end
      assign bars_pix[gi*BPC +: BPC]  = bar_on   ? {BPC{1'b1}} : '0;
      assign check_pix[gi*BPC +: BPC] = check_on ? {BPC{1'b1}} : '0;
      assign grad_pix[gi*BPC +: BPC]  = hpos[BPC-1:0];
    end
  endgenerate

  always_comb begin
    pattern = '0;
    case (cur_mode)
      MODE_BARS:   pattern = bars_pix;
      MODE_CHECK:  pattern = check_pix;
      MODE_GRAD:   pattern = grad_pix;
      MODE_STREAM: pattern = bus.i_pix_valid ? bus.i_pixel : '0;
      default:     pattern = '0;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (cur_mode != MODE_STREAM &&
        (hpos == '0 || hpos == cur_hw - FW'(1) || vpos == '0 || vpos == cur_vh - LW'(1)))
      pattern = '1;
`endif
  end

  // Ready is combinational from the counters so the source sees it in the
  // same cycle the pixel slot is open.
  logic pix_ready;
  assign pix_ready = i_en && !i_reset && active && (cur_mode == MODE_STREAM);
  assign bus.o_pix_ready = pix_ready;

  logic          hsync_reg, vsync_reg, de_reg, frame_start_reg, underflow_reg;
  logic [PW-1:0] pixel_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || !i_en) begin
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      de_reg          <= 1'b0;
      pixel_reg       <= '0;
      frame_start_reg <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      hsync_reg       <= !h_in_sync;
      vsync_reg       <= !v_in_sync;
      de_reg          <= active;
      pixel_reg       <= active ? pattern : '0;
      frame_start_reg <= origin_reg && active;
      underflow_reg   <= pix_ready && !bus.i_pix_valid;
    end
  end

  assign bus.o_hsync       = hsync_reg;
  assign bus.o_vsync       = vsync_reg;
  assign bus.o_de          = de_reg;
  assign bus.o_pixel       = pixel_reg;
  assign bus.o_frame_start = frame_start_reg;
  assign bus.o_underflow   = underflow_reg;
endmodule

// File: tb/tb_vga_mode_pattern_gen.sv
// Self-checking bench for vga_mode_pattern_gen: a spec-level model predicts
// each registered output when the inputs are driven (scoreboard queue),
// table entries add per-run aggregate counts, and hand sequences cover
// mid-frame mode change, stream underflow, rejected geometry and reset.
module tb_vga_mode_pattern_gen;
  localparam int FW = 13, LW = 11, BPC = 8, NCH = 3, PW = NCH * BPC;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [FW-1:0] hw, hp, hs, hr;
  logic [LW-1:0] vh, vp, vs, vr;

  vga_mode_pattern_gen_if #(.PW(PW)) bus ();

  vga_mode_pattern_gen #(.FW(FW), .LW(LW), .BPC(BPC), .NCH(NCH)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode(mode),
    .i_hm_width(hw), .i_hm_porch(hp), .i_hm_synch(hs), .i_hm_raw(hr),
    .i_vm_height(vh), .i_vm_porch(vp), .i_vm_synch(vs), .i_vm_raw(vr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [PW-1:0] pix;
    logic          fs;
    logic          uf;
  } out_t;

  typedef struct packed {
    out_t        o;
    logic [15:0] h;
    logic [15:0] v;
  } exp_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] hw, hp, hs, hr, vh, vp, vs, vr;
    logic [15:0] cycles, e_de, e_hs, e_vs, e_fs, e_uf;
  } vec_t;

  localparam out_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, pix: '0, fs: 1'b0, uf: 1'b0};

  exp_t exp_q[$];
  int   checks = 0, passed = 0;
  int   cnt_de, cnt_hs, cnt_vs, cnt_fs, cnt_uf;
  // model state: counter position and shadowed mode/geometry
  int   mh, mv, smode, sw, sp, ss, sr, svh, svp, svs, svr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic out_t cur_out();
    out_t o;
    o.hs = bus.o_hsync; o.vs = bus.o_vsync; o.de = bus.o_de;
    o.pix = bus.o_pixel; o.fs = bus.o_frame_start; o.uf = bus.o_underflow;
    return o;
  endfunction

  function automatic logic [PW-1:0] exp_pix(input int m, input int h, input int v, input int w,
                                           input int ht, input logic valid, input logic [PW-1:0] pin);
    logic [PW-1:0] r;
    int bar;
    r = '0;
    case (m)
      0: begin
        bar = (h * 8) / w;
        for (int c = 0; c < NCH; c++)
          for (int k = 0; k < 3; k++)
            if ((k % NCH) == c && bar[k]) r[c*BPC +: BPC] = '1;
      end
      1: if ((((h >> 3) ^ (v >> 3)) & 1) == 1) r = '1;
      2: for (int c = 0; c < NCH; c++) r[c*BPC +: BPC] = BPC'(h);
      default: r = valid ? pin : '0;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (m != 3 && (h == 0 || h == w - 1 || v == 0 || v == ht - 1)) r = '1;
`endif
    return r;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; smode = 0;
    sw = 640; sp = 656; ss = 752; sr = 800;
    svh = 480; svp = 490; svs = 492; svr = 525;
  endtask

  task automatic set_geom(input int a, input int b, input int c, input int d,
                          input int e, input int f, input int g, input int k);
    hw = FW'(a); hp = FW'(b); hs = FW'(c); hr = FW'(d);
    vh = LW'(e); vp = LW'(f); vs = LW'(g); vr = LW'(k);
  endtask

  task automatic compare_pending();
    exp_t e;
    out_t a;
    a = cur_out();
    cnt_de += int'(a.de); cnt_hs += int'(!a.hs); cnt_vs += int'(!a.vs);
    cnt_fs += int'(a.fs); cnt_uf += int'(a.uf);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("video h%0d v%0d", e.h, e.v), 64'(a), 64'(e.o));
    end
  endtask

  // Called at a negedge: check the last edge's outputs, drive this cycle,
  // predict the next edge's outputs, then move to the next negedge.
  task automatic cycle(input logic en_v, input logic [1:0] mode_v, input logic valid_v,
                       input logic [PW-1:0] pin);
    exp_t e;
    logic act, rdy;
    compare_pending();
    en = en_v; mode = mode_v; bus.i_pix_valid = valid_v; bus.i_pixel = pin;
    if (mh == 0 && mv == 0) begin
      smode = int'(mode_v);
      if (hw >= 8 && hw <= hp && hp < hs && hs < hr && vh >= 1 && vh <= vp && vp < vs && vs < vr) begin
        sw = int'(hw); sp = int'(hp); ss = int'(hs); sr = int'(hr);
        svh = int'(vh); svp = int'(vp); svs = int'(vs); svr = int'(vr);
      end
    end
    act = (mh < sw) && (mv < svh);
    e.h = 16'(mh); e.v = 16'(mv);
    if (!en_v) begin
      e.o = IDLE;
      rdy = 1'b0;
    end else begin
      e.o.hs  = !(mh >= sp && mh < ss);
      e.o.vs  = !(mv >= svp && mv < svs);
      e.o.de  = act;
      e.o.pix = act ? exp_pix(smode, mh, mv, sw, svh, valid_v, pin) : '0;
      e.o.fs  = (mh == 0 && mv == 0);
      e.o.uf  = act && smode == 3 && !valid_v;
      rdy     = act && smode == 3;
    end
    exp_q.push_back(e);
    #1 chk($sformatf("ready h%0d v%0d", mh, mv), 64'(bus.o_pix_ready), 64'(rdy));
    if (!en_v) begin
      mh = 0; mv = 0;
    end else if (mh == sr - 1) begin
      mh = 0;
      mv = (mv == svr - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    @(negedge clk);
  endtask

  task automatic clear_counts();
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; cnt_uf = 0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{mode: 2'd2, hw: 0, hp: 0, hs: 0, hr: 0, vh: 0, vp: 0, vs: 0, vr: 0,
                cycles: 900, e_de: 740, e_hs: 96, e_vs: 0, e_fs: 1, e_uf: 0};
    vecs[1] = '{mode: 2'd2, hw: 8, hp: 10, hs: 12, hr: 14, vh: 4, vp: 5, vs: 6, vr: 7,
                cycles: 98, e_de: 32, e_hs: 14, e_vs: 14, e_fs: 1, e_uf: 0};
    vecs[2] = '{mode: 2'd0, hw: 8, hp: 10, hs: 12, hr: 14, vh: 4, vp: 5, vs: 6, vr: 7,
                cycles: 98, e_de: 32, e_hs: 14, e_vs: 14, e_fs: 1, e_uf: 0};
    vecs[3] = '{mode: 2'd1, hw: 8, hp: 10, hs: 12, hr: 14, vh: 4, vp: 5, vs: 6, vr: 7,
                cycles: 196, e_de: 64, e_hs: 28, e_vs: 28, e_fs: 2, e_uf: 0};
    vecs[4] = '{mode: 2'd3, hw: 8, hp: 10, hs: 12, hr: 14, vh: 4, vp: 5, vs: 6, vr: 7,
                cycles: 98, e_de: 32, e_hs: 14, e_vs: 14, e_fs: 1, e_uf: 0};

    // reset with stream mode enabled: ready must still be held low
    rst = 1'b1; en = 1'b1; mode = 2'd3; set_geom(0, 0, 0, 0, 0, 0, 0, 0);
    bus.i_pix_valid = 1'b1; bus.i_pixel = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    chk("reset video", 64'(cur_out()), 64'(IDLE));
    chk("reset ready", 64'(bus.o_pix_ready), 64'(0));
    en = 1'b0; rst = 1'b0;
    model_reset();

    // table: geometry latched while disabled, then a fixed enabled run
    for (int i = 0; i < 5; i++) begin
      set_geom(int'(vecs[i].hw), int'(vecs[i].hp), int'(vecs[i].hs), int'(vecs[i].hr),
               int'(vecs[i].vh), int'(vecs[i].vp), int'(vecs[i].vs), int'(vecs[i].vr));
      clear_counts();
      repeat (2) cycle(1'b0, vecs[i].mode, 1'b1, '0);
      for (int n = 0; n < int'(vecs[i].cycles); n++) cycle(1'b1, vecs[i].mode, 1'b1, PW'($urandom));
      cycle(1'b0, vecs[i].mode, 1'b1, '0);
      chk($sformatf("vec%0d de count", i), 64'(cnt_de), 64'(vecs[i].e_de));
      chk($sformatf("vec%0d hsync low count", i), 64'(cnt_hs), 64'(vecs[i].e_hs));
      chk($sformatf("vec%0d vsync low count", i), 64'(cnt_vs), 64'(vecs[i].e_vs));
      chk($sformatf("vec%0d frame_start count", i), 64'(cnt_fs), 64'(vecs[i].e_fs));
      chk($sformatf("vec%0d underflow count", i), 64'(cnt_uf), 64'(vecs[i].e_uf));
    end

    // bars -> gradient requested mid-frame: takes effect at the next origin
    set_geom(8, 10, 12, 14, 4, 5, 6, 7);
    repeat (2) cycle(1'b0, 2'd0, 1'b1, '0);
    for (int n = 0; n < 196; n++) cycle(1'b1, (n < 40) ? 2'd0 : 2'd2, 1'b1, '0);
    cycle(1'b0, 2'd2, 1'b1, '0);

    // stream starved once at hpos 3 of line 0
    clear_counts();
    repeat (2) cycle(1'b0, 2'd3, 1'b1, '0);
    for (int n = 0; n < 98; n++) cycle(1'b1, 2'd3, !(mh == 3 && mv == 0), PW'($urandom));
    cycle(1'b0, 2'd3, 1'b1, '0);
    chk("underflow pulses", 64'(cnt_uf), 64'(1));
    chk("underflow frame de", 64'(cnt_de), 64'(32));

    // rejected geometry (porch < width) must leave 14x7 timing running
    clear_counts();
    repeat (2) cycle(1'b0, 2'd2, 1'b1, '0);
    for (int n = 0; n < 98; n++) cycle(1'b1, 2'd2, 1'b1, '0);
    hp = FW'(5);
    for (int n = 0; n < 200 && !(mh == 6 && mv == 2); n++) cycle(1'b1, 2'd2, 1'b1, '0);
    compare_pending();
    chk("invalid geom de count", 64'(cnt_de), 64'(54));
    chk("invalid geom hsync low count", 64'(cnt_hs), 64'(18));

    // asynchronous reset at hpos 6 line 2
    rst = 1'b1;
    #1;
    chk("async reset video", 64'(cur_out()), 64'(IDLE));
    chk("async reset ready", 64'(bus.o_pix_ready), 64'(0));
    exp_q.delete();
    model_reset();
    hp = FW'(10);
    @(negedge clk);
    chk("reset held video", 64'(cur_out()), 64'(IDLE));
    rst = 1'b0;
    clear_counts();
    for (int n = 0; n < 98; n++) cycle(1'b1, 2'd2, 1'b1, '0);
    cycle(1'b0, 2'd2, 1'b1, '0);
    chk("post-reset frame_start count", 64'(cnt_fs), 64'(1));
    chk("post-reset de count", 64'(cnt_de), 64'(32));
    cycle(1'b0, 2'd2, 1'b1, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
